mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/mem_access.sv | 194 +++++++++++++++++++
 tb/tb_mem_access.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module : mem_access_pkg
// Shared bus widths, access encodings and FSM state for the memory stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int SEL_W      = 4;

  localparam logic [SEL_W-1:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [SEL_W-1:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Caller guarantees at least one of rd/wr is set.
  function automatic logic access_illegal(input logic             rd,
                                          input logic             wr,
                                          input logic [SEL_W-1:0] sel,
                                          input logic [1:0]       addr_lo);
    logic bad_sel;
    logic misaligned;
    bad_sel    = (sel != MEM_SEL_BYTE) && (sel != MEM_SEL_WORD);
    misaligned = (sel == MEM_SEL_WORD) && (addr_lo != 2'b00);
    return bad_sel || misaligned || (rd && wr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module : mem_lane_align
// Byte-lane steering: store replication/enables and load extract/extend.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]       st_addr_lo,
  input  logic [SEL_W-1:0] st_sel,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]       st_be,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [1:0]       ld_addr_lo,
  input  logic [SEL_W-1:0] ld_sel,
  input  logic             ld_sign_ext,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_result
);

  logic [7:0] ld_byte;

  always_comb begin
    st_be     = 4'b1111;
    st_wdata  = st_data;
    ld_byte   = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_result = ld_rdata;
    if (st_sel == MEM_SEL_BYTE) begin
      st_be    = 4'b0001 << st_addr_lo;
      st_wdata = {4{st_data[7:0]}};
    end
    if (ld_sel == MEM_SEL_BYTE) begin
      ld_result = {{24{ld_sign_ext & ld_byte[7]}}, ld_byte};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module : mem_access
// Memory pipeline stage: issues data-RAM requests, stalls upstream, feeds WB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic                  mem_sign_ext_flag,
  input  logic [3:0]            mem_sel,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  input  logic                  write_reg_en_i,
  input  logic [4:0]            write_reg_addr_i,
  output logic                  stall_request,
  output logic                  ram_en,
  output logic [3:0]            ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  input  logic                  ram_ready,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  write_reg_en_o,
  output logic [4:0]            write_reg_addr_o,
  output logic                  addr_error
);

  state_t                  state_q, state_d;
  logic                    lat_read_q, lat_read_d;
  logic                    lat_sign_q, lat_sign_d;
  logic [3:0]              lat_sel_q, lat_sel_d;
  logic [1:0]              lat_addr_lo_q, lat_addr_lo_d;
  logic                    lat_wen_q, lat_wen_d;
  logic [4:0]              lat_waddr_q, lat_waddr_d;
  logic                    ram_en_q, ram_en_d;
  logic [3:0]              ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    wen_q, wen_d;
  logic [4:0]              waddr_q, waddr_d;
  logic                    err_q, err_d;

  logic                    mem_access_req;
  logic                    mem_illegal;
  logic                    mem_legal;
  logic [3:0]              st_be;
  logic [DATA_WIDTH-1:0]   st_wdata;
  logic [DATA_WIDTH-1:0]   ld_result;

  assign mem_access_req = valid_i && (mem_read_flag || mem_write_flag);
  assign mem_illegal    = mem_access_req &&
                          access_illegal(mem_read_flag, mem_write_flag, mem_sel, address_i[1:0]);
  assign mem_legal      = mem_access_req && !mem_illegal;

  // Store side steers the incoming op; load side uses the op latched in BUSY.
  mem_lane_align u_lane (
    .st_addr_lo  (address_i[1:0]),
    .st_sel      (mem_sel),
    .st_data     (mem_write_data),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_addr_lo  (lat_addr_lo_q),
    .ld_sel      (lat_sel_q),
    .ld_sign_ext (lat_sign_q),
    .ld_rdata    (ram_read_data),
    .ld_result   (ld_result)
  );

  always_comb begin
    state_d       = state_q;
    lat_read_d    = lat_read_q;
    lat_sign_d    = lat_sign_q;
    lat_sel_d     = lat_sel_q;
    lat_addr_lo_d = lat_addr_lo_q;
    lat_wen_d     = lat_wen_q;
    lat_waddr_d   = lat_waddr_q;
    ram_en_d      = ram_en_q;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    valid_d       = 1'b0;
    result_d      = result_q;
    wen_d         = 1'b0;
    waddr_d       = waddr_q;
    err_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_legal) begin
          state_d       = ST_BUSY;
          lat_read_d    = mem_read_flag;
          lat_sign_d    = mem_sign_ext_flag;
          lat_sel_d     = mem_sel;
          lat_addr_lo_d = address_i[1:0];
          lat_wen_d     = write_reg_en_i;
          lat_waddr_d   = write_reg_addr_i;
          ram_en_d      = 1'b1;
          ram_addr_d    = {address_i[ADDR_WIDTH-1:2], 2'b00};
          ram_we_d      = mem_write_flag ? st_be : 4'b0000;
          ram_wdata_d   = mem_write_flag ? st_wdata : '0;
        end else if (mem_illegal) begin
          valid_d  = 1'b1;
          err_d    = 1'b1;
          result_d = '0;
          waddr_d  = write_reg_addr_i;
        end else if (valid_i) begin
          valid_d  = 1'b1;
          result_d = result_i;
          wen_d    = write_reg_en_i;
          waddr_d  = write_reg_addr_i;
        end
      end
      ST_BUSY: begin
        if (ram_ready) begin
          state_d  = ST_IDLE;
          ram_en_d = 1'b0;
          ram_we_d = 4'b0000;
          valid_d  = 1'b1;
          result_d = lat_read_q ? ld_result : '0;
          wen_d    = lat_read_q && lat_wen_q;
          waddr_d  = lat_waddr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      lat_read_q    <= 1'b0;
      lat_sign_q    <= 1'b0;
      lat_sel_q     <= 4'b0000;
      lat_addr_lo_q <= 2'b00;
      lat_wen_q     <= 1'b0;
      lat_waddr_q   <= 5'd0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 4'b0000;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      valid_q       <= 1'b0;
      result_q      <= '0;
      wen_q         <= 1'b0;
      waddr_q       <= 5'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_read_q    <= lat_read_d;
      lat_sign_q    <= lat_sign_d;
      lat_sel_q     <= lat_sel_d;
      lat_addr_lo_q <= lat_addr_lo_d;
      lat_wen_q     <= lat_wen_d;
      lat_waddr_q   <= lat_waddr_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      valid_q       <= valid_d;
      result_q      <= result_d;
      wen_q         <= wen_d;
      waddr_q       <= waddr_d;
      err_q         <= err_d;
    end
  end

  assign stall_request = rst && ((state_q == ST_IDLE) ? mem_legal : !ram_ready);

  assign ram_en           = ram_en_q;
  assign ram_write_en     = ram_we_q;
  assign ram_addr         = ram_addr_q;
  assign ram_write_data   = ram_wdata_q;
  assign valid_o          = valid_q;
  assign result_o         = result_q;
  assign write_reg_en_o   = wen_q;
  assign write_reg_addr_o = waddr_q;
  assign addr_error       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module : tb_mem_access
// Directed vector bench for the memory access stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, mem_read_flag, mem_write_flag, mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data, address_i, result_i;
  logic        write_reg_en_i;
  logic [4:0]  write_reg_addr_i;
  logic        stall_request, ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr, ram_write_data, ram_read_data;
  logic        ram_ready;
  logic        valid_o;
  logic [31:0] result_o;
  logic        write_reg_en_o;
  logic [4:0]  write_reg_addr_o;
  logic        addr_error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
    .mem_write_data(mem_write_data), .address_i(address_i), .result_i(result_i),
    .write_reg_en_i(write_reg_en_i), .write_reg_addr_i(write_reg_addr_i),
    .stall_request(stall_request), .ram_en(ram_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .ram_ready(ram_ready),
    .valid_o(valid_o), .result_o(result_o), .write_reg_en_o(write_reg_en_o),
    .write_reg_addr_o(write_reg_addr_o), .addr_error(addr_error)
  );

  typedef struct {
    logic        v, rd, wr, sx;
    logic [3:0]  sel;
    logic [31:0] addr, res;
    logic        wen;
    logic [4:0]  waddr;
    logic        rdy;
    logic        e_valid, e_wen, e_err, chk_res;
    logic [31:0] e_res;
    logic [4:0]  e_waddr;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic sx,
                       input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] res, input logic wen, input logic [4:0] waddr);
    valid_i = v; mem_read_flag = rd; mem_write_flag = wr; mem_sign_ext_flag = sx;
    mem_sel = sel; mem_write_data = wdata; address_i = addr; result_i = res;
    write_reg_en_i = wen; write_reg_addr_i = waddr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Legal memory op from IDLE with 'waits' not-ready cycles before ram_ready.
  task automatic mem_op(input string nm, input logic rd, input logic wr, input logic sx,
                        input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] addr,
                        input int waits, input logic [31:0] rdata,
                        input logic [3:0] e_we, input logic [31:0] e_wdata, input logic [31:0] e_addr,
                        input logic [31:0] e_res, input logic e_wen);
    int stalls;
    stalls = 0;
    drive(1'b1, rd, wr, sx, sel, wdata, addr, 32'h0, 1'b1, 5'd7);
    ram_ready = 1'b0;
    ram_read_data = 32'h0;
    #1;
    if (stall_request) stalls++;
    next_cycle();
    for (int i = 0; i <= waits; i++) begin
      ram_ready = (i == waits);
      ram_read_data = (i == waits) ? rdata : 32'hDEAD_0000;
      #1;
      if (stall_request) stalls++;
      chk({nm, "_ram_en"}, {31'd0, ram_en}, 32'd1);
      chk({nm, "_ram_addr"}, ram_addr, e_addr);
      chk({nm, "_ram_we"}, {28'd0, ram_write_en}, {28'd0, e_we});
      if (wr) chk({nm, "_ram_wdata"}, ram_write_data, e_wdata);
      chk({nm, "_valid_busy"}, {31'd0, valid_o}, 32'd0);
      next_cycle();
    end
    ram_ready = 1'b0;
    valid_i = 1'b0;
    chk({nm, "_valid"}, {31'd0, valid_o}, 32'd1);
    if (rd) chk({nm, "_result"}, result_o, e_res);
    chk({nm, "_wen"}, {31'd0, write_reg_en_o}, {31'd0, e_wen});
    chk({nm, "_ram_en_done"}, {31'd0, ram_en}, 32'd0);
    chk({nm, "_stall_cycles"}, stalls, 1 + waits);
  endtask

  initial begin
    int stalls;
    tbl[0] = '{1'b1,1'b0,1'b0,1'b0,4'b0000,32'h0,    32'h11,       1'b1,5'd5, 1'b0, 1'b1,1'b1,1'b0,1'b1,32'h11,       5'd5};
    tbl[1] = '{1'b0,1'b0,1'b0,1'b0,4'b0000,32'h0,    32'h0,        1'b1,5'd7, 1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,        5'd0};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b0,4'b1111,32'h3002, 32'h0,        1'b1,5'd9, 1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0,        5'd0};
    tbl[3] = '{1'b1,1'b0,1'b0,1'b0,4'b0000,32'h0,    32'hDEADBEEF, 1'b0,5'd31,1'b0, 1'b1,1'b0,1'b0,1'b1,32'hDEADBEEF, 5'd31};
    tbl[4] = '{1'b1,1'b0,1'b1,1'b0,4'b0011,32'h100,  32'h0,        1'b0,5'd0, 1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0,        5'd0};
    tbl[5] = '{1'b1,1'b1,1'b1,1'b0,4'b0001,32'h101,  32'h0,        1'b1,5'd2, 1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0,        5'd0};
    tbl[6] = '{1'b1,1'b0,1'b1,1'b0,4'b1111,32'h106,  32'h0,        1'b0,5'd0, 1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0,        5'd0};
    tbl[7] = '{1'b0,1'b0,1'b0,1'b0,4'b0000,32'h0,    32'h0,        1'b0,5'd0, 1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0,        5'd0};
    tbl[8] = '{1'b1,1'b0,1'b0,1'b0,4'b0011,32'h3,    32'h55,       1'b1,5'd4, 1'b1, 1'b1,1'b1,1'b0,1'b1,32'h55,       5'd4};

    // Reset with a legal load presented: no stall, all outputs cleared.
    rst = 1'b0;
    ram_ready = 1'b0;
    ram_read_data = 32'h0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h40, 32'h0, 1'b1, 5'd1);
    @(negedge clk);
    next_cycle();
    chk("rst_stall", {31'd0, stall_request}, 32'd0);
    chk("rst_outs", {valid_o, write_reg_en_o, addr_error, ram_en, ram_write_en, write_reg_addr_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_write_data, 32'd0);
    valid_i = 1'b0;
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].sx, tbl[i].sel, 32'h0, tbl[i].addr,
            tbl[i].res, tbl[i].wen, tbl[i].waddr);
      ram_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, stall_request}, 32'd0);
      next_cycle();
      chk($sformatf("vec%0d_ram_en", i), {31'd0, ram_en}, 32'd0);
      chk($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d_wen", i), {31'd0, write_reg_en_o}, {31'd0, tbl[i].e_wen});
      chk($sformatf("vec%0d_err", i), {31'd0, addr_error}, {31'd0, tbl[i].e_err});
      if (tbl[i].chk_res) begin
        chk($sformatf("vec%0d_result", i), result_o, tbl[i].e_res);
        chk($sformatf("vec%0d_waddr", i), {27'd0, write_reg_addr_o}, {27'd0, tbl[i].e_waddr});
      end
    end
    valid_i = 1'b0;
    ram_ready = 1'b0;
    next_cycle();

    mem_op("lb",  1'b1, 1'b0, 1'b1, 4'b0001, 32'h0, 32'h1003, 2, 32'h80FF_1234,
           4'b0000, 32'h0, 32'h1000, 32'hFFFF_FF80, 1'b1);
    mem_op("lbu", 1'b1, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h1002, 1, 32'h80FF_1234,
           4'b0000, 32'h0, 32'h1000, 32'h0000_00FF, 1'b1);
    mem_op("sb",  1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_00A5, 32'h2001, 0, 32'h0,
           4'b0010, 32'hA5A5_A5A5, 32'h2000, 32'h0, 1'b0);
    mem_op("lw",  1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h3004, 0, 32'hCAFE_F00D,
           4'b0000, 32'h0, 32'h3004, 32'hCAFE_F00D, 1'b1);

    // ADD, SW, ADD back to back with zero-wait RAM: a single stall cycle.
    stalls = 0;
    ram_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h1, 1'b1, 5'd3);
    #1; if (stall_request) stalls++;
    next_cycle();
    chk("b2b_add1_valid", {31'd0, valid_o}, 32'd1);
    chk("b2b_add1_result", result_o, 32'h1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h1234_5678, 32'h40, 32'h0, 1'b0, 5'd0);
    #1; if (stall_request) stalls++;
    next_cycle();
    #1; if (stall_request) stalls++;
    chk("b2b_sw_ram_en", {31'd0, ram_en}, 32'd1);
    chk("b2b_sw_we", {28'd0, ram_write_en}, 32'hF);
    chk("b2b_sw_wdata", ram_write_data, 32'h1234_5678);
    chk("b2b_sw_addr", ram_addr, 32'h40);
    next_cycle();
    chk("b2b_sw_valid", {31'd0, valid_o}, 32'd1);
    chk("b2b_sw_wen", {31'd0, write_reg_en_o}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h2, 1'b1, 5'd6);
    #1; if (stall_request) stalls++;
    next_cycle();
    chk("b2b_add2_valid", {31'd0, valid_o}, 32'd1);
    chk("b2b_add2_result", result_o, 32'h2);
    chk("b2b_stalls", stalls, 1);
    valid_i = 1'b0;
    ram_ready = 1'b0;
    next_cycle();

    // Reset while BUSY abandons the access; a later ready is ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h50, 32'h0, 1'b1, 5'd8);
    next_cycle();
    chk("rb_busy_ram_en", {31'd0, ram_en}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rb_stall_in_rst", {31'd0, stall_request}, 32'd0);
    next_cycle();
    chk("rb_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rb_valid", {31'd0, valid_o}, 32'd0);
    rst = 1'b1;
    valid_i = 1'b0;
    ram_ready = 1'b1;
    ram_read_data = 32'h1111_1111;
    next_cycle();
    chk("rb_late_ready_valid", {31'd0, valid_o}, 32'd0);
    chk("rb_late_ready_ram_en", {31'd0, ram_en}, 32'd0);
    next_cycle();
    chk("rb_late_ready_valid2", {31'd0, valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
